// File: rtl/matrix_key_scan.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces
// press and release, and emits a single-cycle key code per physical press.
module matrix_key_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_val,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [3:0]    row_meta_r, row_sync_r;
  logic [DW-1:0] dwell_r, dwell_s;
  logic [1:0]    col_idx_r, col_idx_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [1:0]    hit_row_r, hit_row_s;
  logic [3:0]    pat_r, pat_s;
  logic [3:0]    key_col_r, key_col_s;
  logic [3:0]    key_val_r, key_val_s;
  logic          key_valid_r, key_valid_s;
  logic          key_down_r, key_down_s;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b0000: code = 4'h1;
      4'b0001: code = 4'h2;
      4'b0010: code = 4'h3;
      4'b0011: code = 4'hA;
      4'b0100: code = 4'h4;
      4'b0101: code = 4'h5;
      4'b0110: code = 4'h6;
      4'b0111: code = 4'hB;
      4'b1000: code = 4'h7;
      4'b1001: code = 4'h8;
      4'b1010: code = 4'h9;
      4'b1011: code = 4'hC;
      4'b1100: code = 4'hE;
      4'b1101: code = 4'h0;
      4'b1110: code = 4'hF;
      4'b1111: code = 4'hD;
      default: code = 4'hF;
    endcase
    return code;
  endfunction

  // Several rows low in one column: the lowest index wins.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

  // Next-state, counter and output decode for the scan/debounce/hold sequence.
  always_comb begin
    state_s     = state_r;
    dwell_s     = dwell_r;
    col_idx_s   = col_idx_r;
    cnt_s       = cnt_r;
    hit_row_s   = hit_row_r;
    pat_s       = pat_r;
    key_val_s   = 4'hF;
    key_valid_s = 1'b0;
    case (state_r)
      ST_SCAN: begin
        if (dwell_r == DWELL_LAST) begin
          dwell_s = {DW{1'b0}};
          if (row_sync_r != 4'hF) begin
            hit_row_s = lowest_low(row_sync_r);
            pat_s     = row_sync_r;
            cnt_s     = {CW{1'b0}};
            state_s   = ST_DEBOUNCE;
          end else begin
            col_idx_s = col_idx_r + 2'd1;
          end
        end else begin
          dwell_s = dwell_r + DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (row_sync_r != pat_r) begin
          state_s   = ST_SCAN;
          col_idx_s = col_idx_r + 2'd1;
          dwell_s   = {DW{1'b0}};
          cnt_s     = {CW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
          key_val_s   = key_code(hit_row_r, col_idx_r);
          key_valid_s = 1'b1;
          cnt_s       = {CW{1'b0}};
          state_s     = ST_HOLD;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_HOLD: begin
        // Release needs an unbroken run of all-high cycles.
        if (row_sync_r != 4'hF) begin
          cnt_s = {CW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
          state_s   = ST_SCAN;
          col_idx_s = col_idx_r + 2'd1;
          dwell_s   = {DW{1'b0}};
          cnt_s     = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s   = ST_SCAN;
        col_idx_s = 2'd0;
        dwell_s   = {DW{1'b0}};
        cnt_s     = {CW{1'b0}};
      end
    endcase
    key_down_s = (state_s == ST_HOLD);
    key_col_s  = ~(4'b0001 << col_idx_s);
  end

  // Row synchronizer plus all state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_r  <= 4'hF;
      row_sync_r  <= 4'hF;
      state_r     <= ST_SCAN;
      dwell_r     <= {DW{1'b0}};
      col_idx_r   <= 2'd0;
      cnt_r       <= {CW{1'b0}};
      hit_row_r   <= 2'd0;
      pat_r       <= 4'hF;
      key_col_r   <= 4'b1110;
      key_val_r   <= 4'hF;
      key_valid_r <= 1'b0;
      key_down_r  <= 1'b0;
    end else begin
      row_meta_r  <= key_row;
      row_sync_r  <= row_meta_r;
      state_r     <= state_s;
      dwell_r     <= dwell_s;
      col_idx_r   <= col_idx_s;
      cnt_r       <= cnt_s;
      hit_row_r   <= hit_row_s;
      pat_r       <= pat_s;
      key_col_r   <= key_col_s;
      key_val_r   <= key_val_s;
      key_valid_r <= key_valid_s;
      key_down_r  <= key_down_s;
    end
  end

  assign key_col   = key_col_r;
  assign key_val   = key_val_r;
  assign key_valid = key_valid_r;
  assign key_down  = key_down_r;

endmodule
